// File: rtl/ltssm_pkg.sv
// Shared LTSSM encodings (substates, timer codes, ordered-set types) used by the
// transmit and receive LTSSM blocks, plus the per-substate load table.
package ltssm_pkg;

    localparam int SUBSTATE_W = 4;
    localparam int LANES_W    = 5;
    localparam int LANE_CNT   = 16;
    localparam int COUNT_W    = 11;

    localparam logic [SUBSTATE_W-1:0] LAST_STATE_RESET = 4'hF;

    typedef enum logic [SUBSTATE_W-1:0] {
        SUB_DETECT_QUIET             = 4'd0,
        SUB_DETECT_ACTIVE            = 4'd1,
        SUB_POLLING_ACTIVE           = 4'd2,
        SUB_POLLING_CONFIGURATION    = 4'd3,
        SUB_CONFIG_LINKWIDTH_START   = 4'd4,
        SUB_CONFIG_LINKWIDTH_ACCEPT  = 4'd5,
        SUB_CONFIG_LANENUM_WAIT      = 4'd6,
        SUB_CONFIG_LANENUM_ACCEPT    = 4'd7,
        SUB_CONFIG_COMPLETE          = 4'd8,
        SUB_CONFIG_IDLE              = 4'd9,
        SUB_L0                       = 4'd10
    } substate_t;

    typedef enum logic [2:0] {
        T0MS  = 3'b000,
        T12MS = 3'b001,
        T24MS = 3'b010,
        T48MS = 3'b011,
        T2MS  = 3'b100,
        T8MS  = 3'b101
    } timer_code_t;

    typedef enum logic [1:0] {
        OS_NONE = 2'b00,
        OS_TS1  = 2'b01,
        OS_TS2  = 2'b10,
        OS_IDLE = 2'b11
    } os_type_t;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_SENDING = 2'd1,
        ST_SUCCESS = 2'd2,
        ST_FAILED  = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic                valid;
        os_type_t            os_type;
        logic [COUNT_W-1:0]  target;
        timer_code_t         time_to_wait;
    } substate_load_t;

    // Substates outside detect..configurationIdle (L0 and unused codes) never start a sequence.
    function automatic substate_load_t substate_load(input logic [SUBSTATE_W-1:0] sub);
        substate_load_t load;
        load = '{valid: 1'b0, os_type: OS_NONE, target: '0, time_to_wait: T0MS};
        case (sub)
            SUB_DETECT_QUIET:            load = '{1'b1, OS_NONE, 11'd0,    T12MS};
            SUB_DETECT_ACTIVE:           load = '{1'b1, OS_NONE, 11'd0,    T0MS};
            SUB_POLLING_ACTIVE:          load = '{1'b1, OS_TS1,  11'd1024, T24MS};
            SUB_POLLING_CONFIGURATION:   load = '{1'b1, OS_TS2,  11'd16,   T48MS};
            SUB_CONFIG_LINKWIDTH_START:  load = '{1'b1, OS_TS1,  11'd16,   T24MS};
            SUB_CONFIG_LINKWIDTH_ACCEPT: load = '{1'b1, OS_TS1,  11'd16,   T24MS};
            SUB_CONFIG_LANENUM_WAIT:     load = '{1'b1, OS_TS1,  11'd16,   T2MS};
            SUB_CONFIG_LANENUM_ACCEPT:   load = '{1'b1, OS_TS2,  11'd16,   T24MS};
            SUB_CONFIG_COMPLETE:         load = '{1'b1, OS_TS2,  11'd16,   T24MS};
            SUB_CONFIG_IDLE:             load = '{1'b1, OS_IDLE, 11'd16,   T2MS};
            default:                     load = '{1'b0, OS_NONE, 11'd0,    T0MS};
        endcase
        return load;
    endfunction

endpackage

// File: rtl/master_tx_ltssm_if.sv
// Handshake bundle between the main LTSSM / ordered-set generator / timer and
// the transmit LTSSM; master is the transmit LTSSM side.
interface master_tx_ltssm_if;
    import ltssm_pkg::*;

    logic [SUBSTATE_W-1:0] substate;
    logic [LANES_W-1:0]    numberOfDetectedLanes;
    logic                  osSent;
    logic                  timeOut;

    logic                  finish;
    logic [SUBSTATE_W-1:0] exitTo;
    logic [1:0]            osType;
    logic                  enableOsGen;
    logic [LANE_CNT-1:0]   laneEnable;
    logic                  disableScrambler;
    logic [2:0]            timeToWait;
    logic                  enableTimer;
    logic                  startTimer;
    logic                  resetTimer;

    modport master (
        input  substate, numberOfDetectedLanes, osSent, timeOut,
        output finish, exitTo, osType, enableOsGen, laneEnable, disableScrambler,
               timeToWait, enableTimer, startTimer, resetTimer
    );

    modport slave (
        output substate, numberOfDetectedLanes, osSent, timeOut,
        input  finish, exitTo, osType, enableOsGen, laneEnable, disableScrambler,
               timeToWait, enableTimer, startTimer, resetTimer
    );

endinterface

// File: rtl/lane_mask_decode.sv
// Converts the detected lane count into a contiguous per-lane transmit mask;
// unsupported widths or no ordered set to send give an all-off mask.
module lane_mask_decode
    import ltssm_pkg::*;
(
    input  logic [LANES_W-1:0]  lanes,
    input  os_type_t            os_type,
    output logic [LANE_CNT-1:0] mask
);

    always_comb begin
        mask = '0;
        if (os_type != OS_NONE) begin
            case (lanes)
                5'd1:    mask = 16'h0001;
                5'd2:    mask = 16'h0003;
                5'd4:    mask = 16'h000F;
                5'd8:    mask = 16'h00FF;
                5'd16:   mask = 16'hFFFF;
                default: mask = 16'h0000;
            endcase
        end
    end

endmodule

// File: rtl/master_tx_ltssm.sv
// Transmit-side LTSSM: for each new substate request it drives the ordered-set
// generator and timer, counts completed ordered sets and reports success/failure.
module master_tx_ltssm
    import ltssm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    master_tx_ltssm_if.master   bus
);

    tx_state_t             state;
    tx_state_t             state_next;
    substate_load_t        load;
    logic                  accept;
    os_type_t              os_type_q;
    os_type_t              os_type_d;
    timer_code_t           time_q;
    logic [COUNT_W-1:0]    target_q;
    logic [COUNT_W-1:0]    count_q;
    logic [COUNT_W:0]      count_inc;
    logic [SUBSTATE_W-1:0] req_sub_q;
    logic [SUBSTATE_W-1:0] last_state;
    logic                  disable_scr_q;
    logic [LANE_CNT-1:0]   lane_mask;
    logic [LANE_CNT-1:0]   lane_enable_q;

    // Mask follows the ordered-set type being registered this cycle so both change together.
    lane_mask_decode u_lane_mask_decode (
        .lanes   (bus.numberOfDetectedLanes),
        .os_type (os_type_d),
        .mask    (lane_mask)
    );

    // Acceptance is held off while reset is asserted so no timer pulse escapes during reset.
    always_comb begin
        load       = substate_load(bus.substate);
        count_inc  = {1'b0, count_q} + 12'd1;
        state_next = state;
        accept     = 1'b0;
        os_type_d  = os_type_q;
        case (state)
            ST_START: begin
                if (reset && (bus.substate != last_state) && load.valid) begin
                    accept     = 1'b1;
                    os_type_d  = load.os_type;
                    state_next = ST_SENDING;
                end
            end
            ST_SENDING: begin
                if (target_q == '0) begin
                    if (bus.timeOut) begin
                        state_next = ST_SUCCESS;
                    end
                end else if (bus.osSent && (count_inc == {1'b0, target_q})) begin
                    state_next = ST_SUCCESS;
                end else if (bus.timeOut) begin
                    state_next = ST_FAILED;
                end
            end
            ST_SUCCESS, ST_FAILED: begin
                os_type_d  = OS_NONE;
                state_next = ST_START;
            end
            default: begin
                state_next = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_START;
            os_type_q     <= OS_NONE;
            time_q        <= T0MS;
            target_q      <= '0;
            count_q       <= '0;
            req_sub_q     <= '0;
            last_state    <= LAST_STATE_RESET;
            disable_scr_q <= 1'b1;
            lane_enable_q <= '0;
        end else begin
            state         <= state_next;
            os_type_q     <= os_type_d;
            lane_enable_q <= lane_mask;
            if (accept) begin
                time_q    <= load.time_to_wait;
                target_q  <= load.target;
                req_sub_q <= bus.substate;
                count_q   <= '0;
                if (bus.substate == SUB_DETECT_QUIET) begin
                    disable_scr_q <= 1'b1;
                end
            end
            if ((state == ST_START) && (bus.substate == SUB_L0)) begin
                disable_scr_q <= 1'b0;
            end
            if ((state == ST_SENDING) && bus.osSent && (count_q != '1)) begin
                count_q <= count_q + 11'd1;
            end
            if ((state == ST_SUCCESS) || (state == ST_FAILED)) begin
                last_state <= req_sub_q;
                count_q    <= '0;
            end
        end
    end

    assign bus.finish           = (state == ST_SUCCESS) || (state == ST_FAILED);
    assign bus.exitTo           = (state == ST_SUCCESS) ? (req_sub_q + 4'd1) : 4'd0;
    assign bus.osType           = os_type_q;
    assign bus.enableOsGen      = (state == ST_SENDING);
    assign bus.laneEnable       = lane_enable_q;
    assign bus.disableScrambler = disable_scr_q;
    assign bus.timeToWait       = time_q;
    assign bus.startTimer       = accept;
    assign bus.enableTimer      = accept || (state == ST_SENDING);
    assign bus.resetTimer       = (state == ST_SENDING);

endmodule

// File: tb/tb_master_tx_ltssm.sv
// Directed-plus-random bench for the transmit LTSSM; outcomes come from a
// count-based model of the substate table and success/failure rules.
module tb_master_tx_ltssm;

    logic clk;
    logic reset;

    master_tx_ltssm_if bus();

    master_tx_ltssm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         check_count  = 0;
    int         fail_count   = 0;
    int         finish_count = 0;
    int         start_count  = 0;
    logic [3:0] last_exit    = '0;
    int         lane_opts [8] = '{1, 2, 4, 8, 16, 0, 3, 5};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.finish === 1'b1) begin
            finish_count++;
            last_exit = bus.exitTo;
        end
        if (bus.startTimer === 1'b1) begin
            start_count++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed no summary, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int spec_target(input int sub);
        if (sub == 2) return 1024;
        if (sub >= 3 && sub <= 9) return 16;
        return 0;
    endfunction

    function automatic int spec_os(input int sub);
        case (sub)
            2, 4, 5, 6: return 1;
            3, 7, 8:    return 2;
            9:          return 3;
            default:    return 0;
        endcase
    endfunction

    function automatic int spec_time(input int sub);
        case (sub)
            0:          return 1;
            3:          return 3;
            6, 9:       return 4;
            2, 4, 5, 7, 8: return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic int spec_lanes(input int n, input int os);
        if (os == 0) return 0;
        if (n == 1 || n == 2 || n == 4 || n == 8 || n == 16) return (1 << n) - 1;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_finish"},    32'(bus.finish), 0);
        check({tag, "_exit_to"},   32'(bus.exitTo), 0);
        check({tag, "_os_type"},   32'(bus.osType), 0);
        check({tag, "_os_gen"},    32'(bus.enableOsGen), 0);
        check({tag, "_lanes"},     32'(bus.laneEnable), 0);
        check({tag, "_scrambler"}, 32'(bus.disableScrambler), 1);
        check({tag, "_time"},      32'(bus.timeToWait), 0);
        check({tag, "_en_timer"},  32'(bus.enableTimer), 0);
        check({tag, "_st_timer"},  32'(bus.startTimer), 0);
        check({tag, "_rst_timer"}, 32'(bus.resetTimer), 0);
    endtask

    // One full request: accept, n_os ordered sets with random gaps, optional timeout.
    task automatic run_seq(input int sub, input int n_os, input bit to_end,
                           input bit coincide, input bit perturb);
        int fin0;
        int target;
        int lanes;
        int exp_exit;
        bit success;
        target = spec_target(sub);
        lanes  = int'(bus.numberOfDetectedLanes);
        bus.substate = 4'(sub);
        #1;
        check("start_timer_accept", 32'(bus.startTimer), 1);
        check("enable_timer_accept", 32'(bus.enableTimer), 1);
        step();
        check("os_type_load", 32'(bus.osType), 32'(spec_os(sub)));
        check("time_to_wait_load", 32'(bus.timeToWait), 32'(spec_time(sub)));
        check("os_gen_sending", 32'(bus.enableOsGen), 1);
        check("reset_timer_sending", 32'(bus.resetTimer), 1);
        check("lane_enable", 32'(bus.laneEnable), 32'(spec_lanes(lanes, spec_os(sub))));
        if (sub == 0) check("scrambler_detect_quiet", 32'(bus.disableScrambler), 1);
        fin0 = finish_count;
        for (int i = 0; i < n_os; i++) begin
            if (i == n_os - 1) check("still_sending", 32'(bus.enableOsGen), 1);
            bus.osSent = 1'b1;
            if (coincide && i == n_os - 1) bus.timeOut = 1'b1;
            if (perturb && i == 1) bus.substate = 4'((sub + 5) % 11);
            if (perturb && i == 2) bus.substate = 4'(sub);
            step();
            bus.osSent  = 1'b0;
            bus.timeOut = 1'b0;
            repeat ($urandom_range(0, 1)) step();
        end
        if (to_end) begin
            bus.timeOut = 1'b1;
            step();
            bus.timeOut = 1'b0;
        end
        step();
        step();
        success  = (target == 0) ? (to_end || coincide) : (n_os >= target);
        exp_exit = success ? sub + 1 : 0;
        check("finish_pulses", 32'(finish_count - fin0), 1);
        check("exit_to", 32'(last_exit), 32'(exp_exit));
        check("os_type_cleared", 32'(bus.osType), 0);
        check("os_gen_idle", 32'(bus.enableOsGen), 0);
        check("lane_enable_idle", 32'(bus.laneEnable), 0);
    endtask

    initial begin
        int fin0;
        int st0;
        int sub;
        int prev;
        int n_os;

        reset = 1'b0;
        bus.substate = 4'hF;
        bus.numberOfDetectedLanes = 5'd16;
        bus.osSent  = 1'b0;
        bus.timeOut = 1'b0;
        step();
        step();
        check_reset_values("reset");
        bus.substate = 4'd2;
        #1;
        check("no_accept_in_reset", 32'(bus.startTimer), 0);
        bus.substate = 4'hF;
        reset = 1'b1;
        step();
        check("idle_same_substate", 32'(bus.startTimer), 0);
        check("idle_no_os_gen", 32'(bus.enableOsGen), 0);

        $display("[TB] pollingActive, 1024 TS1, 16 lanes");
        run_seq(2, 1024, 0, 0, 0);

        $display("[TB] pollingConfiguration, 10 TS2 then timeout");
        bus.numberOfDetectedLanes = 5'(lane_opts[$urandom_range(0, 7)]);
        run_seq(3, 10, 1, 0, 0);

        $display("[TB] configurationIdle, 16th ordered set coincides with timeout");
        bus.numberOfDetectedLanes = 5'(lane_opts[$urandom_range(0, 7)]);
        run_seq(9, 16, 0, 1, 0);

        $display("[TB] configurationComplete with 4 lanes, lanenumAccept with 3 lanes");
        bus.numberOfDetectedLanes = 5'd4;
        run_seq(8, 16, 0, 0, 0);
        bus.numberOfDetectedLanes = 5'd3;
        run_seq(7, 16, 0, 0, 1);

        $display("[TB] detect substates finish on timeout");
        run_seq(0, 0, 1, 0, 0);
        run_seq(1, 0, 1, 0, 0);

        $display("[TB] randomized configuration sequences");
        prev = 1;
        for (int k = 0; k < 6; k++) begin
            sub = $urandom_range(3, 9);
            if (sub == prev) sub = (sub == 9) ? 3 : sub + 1;
            prev = sub;
            n_os = $urandom_range(12, 16);
            bus.numberOfDetectedLanes = 5'(lane_opts[$urandom_range(0, 7)]);
            run_seq(sub, n_os, n_os < 16, 0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] L0 enables scrambler and holds without requests");
        bus.substate = 4'd10;
        #1;
        check("l0_no_start", 32'(bus.startTimer), 0);
        step();
        check("l0_scrambler_on", 32'(bus.disableScrambler), 0);
        st0  = start_count;
        fin0 = finish_count;
        repeat (100) step();
        check("l0_no_new_request", 32'(start_count - st0), 0);
        check("l0_no_finish", 32'(finish_count - fin0), 0);
        check("l0_scrambler_held", 32'(bus.disableScrambler), 0);
        run_seq(0, 0, 1, 0, 0);

        $display("[TB] reset in the middle of pollingActive");
        bus.numberOfDetectedLanes = 5'd8;
        bus.substate = 4'd2;
        #1;
        step();
        fin0 = finish_count;
        repeat (500) begin
            bus.osSent = 1'b1;
            step();
            bus.osSent = 1'b0;
        end
        reset = 1'b0;
        #1;
        check_reset_values("abort");
        step();
        step();
        check("abort_no_finish", 32'(finish_count - fin0), 0);
        reset = 1'b1;
        run_seq(2, 1024, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/master_tx_ltssm.md
MASTER_TX_LTSSM -- requirements
Module: master_tx_ltssm

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: clk, reset (reset asserted when low).
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  async active-low reset.
REQ-003 SHALL have ports: substate  in  4  LTSSM substate request from main LTSSM; numberOfDetectedLanes  in  5  active lanes (1/2/4/8/16); osSent  in  1  one-cycle pulse per ordered set completed on all active lanes; timeOut  in  1  timer expiry.
REQ-004 SHALL have ports: finish  out  1  one-cycle done pulse; exitTo  out  4  next substate; osType  out  2  OS to generate (00 none, 01 TS1, 10 TS2, 11 IDLE); enableOsGen  out  1  OS generator enable; laneEnable  out  16  per-lane transmit enable; disableScrambler  out  1; timeToWait  out  3; enableTimer, startTimer, resetTimer  out  1 each.

Function
REQ-005 SHALL implement states START, SENDING, SUCCESS, FAILED (2-bit).
REQ-006 In START, a request SHALL be accepted only when substate differs from registered lastState; otherwise outputs idle (enableOsGen=0, timer controls 0) and state stays START.
REQ-007 On acceptance, SHALL register osType, target count and timeToWait, pulse startTimer=1 and enableTimer=1 for that cycle, then enter SENDING next cycle.
REQ-008 Per-substate load: detectQuiet -> none, target 0, t12ms; detectActive -> none, target 0, t0ms; pollingActive -> TS1, 1024, t24ms; pollingConfiguration -> TS2, 16, t48ms; configurationLinkWidthStart/LinkWidthAccept/LanenumWait -> TS1, 16, t24ms (LanenumWait t2ms); configurationLanenumAccept/configurationComplete -> TS2, 16, t24ms; configurationIdle -> IDLE, 16, t2ms.
REQ-009 substate L0 in START SHALL set disableScrambler=0 (held until reset or a detectQuiet request) and remain in START with no finish.
REQ-010 In SENDING: enableOsGen=1, enableTimer=1, resetTimer=1; an 11-bit counter SHALL increment on each osSent, saturating at 2047.
REQ-011 SENDING -> SUCCESS when count (including the current osSent) reaches target; target 0 substates go to SUCCESS on timeOut.
REQ-012 SENDING -> FAILED on timeOut with count below target; if osSent completing the target and timeOut coincide, SUCCESS wins.
REQ-013 SUCCESS: finish=1 one cycle, exitTo=substate+1, lastState<=substate, enableOsGen=0, counter cleared, -> START.
REQ-014 FAILED: finish=1 one cycle, exitTo=detectQuiet (0), lastState<=substate, enableOsGen=0, counter cleared, -> START.
REQ-015 laneEnable SHALL equal low numberOfDetectedLanes bits set (1->0x0001, 2->0x0003, 4->0x000F, 8->0x00FF, 16->0xFFFF); other values -> 0x0000; forced 0x0000 when osType=none.
REQ-016 A substate change while in SENDING SHALL be ignored until the current sequence finishes.
REQ-017 All outputs SHALL be registered or decoded from registered state only (no latches); every combinational output has a default.

Reset
REQ-018 On reset low: state=START, lastState=4'hF, counter=0, finish=0, exitTo=0, osType=00, enableOsGen=0, laneEnable=0, disableScrambler=1, timeToWait=000, all timer controls 0.
REQ-019 Reset mid-SENDING SHALL abort immediately with no finish pulse; after release a repeated substate is treated as new.

Structure
REQ-020 Substate encodings (detectQuiet=0 ... L0=10), timer codes (t0=000, t12=001, t24=010, t48=011, t2=100, t8=101) and osType codes SHALL live in shared package ltssm_pkg, common with the receive LTSSM.
REQ-021 Lane-mask decode SHALL be sub-module lane_mask_decode; counter and FSM stay in master_tx_ltssm.

Verification
REQ-022 substate=pollingActive, 1024 osSent pulses, no timeOut -> osType=01, finish pulse, exitTo=3.
REQ-023 substate=pollingConfiguration, 10 osSent then timeOut -> finish, exitTo=0, osType returns 00.
REQ-024 substate=configurationIdle, 16th osSent same cycle as timeOut -> exitTo=10 (success).
REQ-025 numberOfDetectedLanes=4, substate=configurationComplete -> laneEnable=0x000F, osType=10; numberOfDetectedLanes=3 -> 0x0000.
REQ-026 Reset asserted after 500 TS1 in pollingActive -> all outputs at reset values, no finish; re-request pollingActive restarts count from 0.
REQ-027 substate=L0 -> disableScrambler=0, no finish; same substate held 100 cycles -> no new request.
